// File: rtl/adc_link_pkg.sv
// adc_link_pkg: shared types and constants for the serial ADC link emulator.
package adc_link_pkg;

  typedef enum logic [1:0] {IDLE, ZEROS, DATA, DONE} adc_state_e;

  localparam int DEF_DATA_W     = 12;
  localparam int DEF_LEAD_ZEROS = 4;
  localparam int FRAME_BITS     = DEF_LEAD_ZEROS + DEF_DATA_W;

  // Galois LFSR used by the optional dither path
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/edge_sync.sv
// edge_sync: STAGES-deep synchroniser for an asynchronous level, followed by
// one history flop that turns synced level changes into one-cycle pulses.
module edge_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic d,
  output logic fall,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the async level in and keep the previous synced value for edge detection
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign fall = prev_q & ~sync_q[STAGES-1];
  assign rise = ~prev_q & sync_q[STAGES-1];

endmodule

// File: rtl/adc_serial_responder.sv
// adc_serial_responder: slave end of the 12-bit serial ADC link. Shifts out
// LEAD_ZEROS zeros then the sample MSB first, advancing on Clock_Muestreo falls.
// Optional macro ADC_DITHER_EN adds +/-1 LSB LFSR dither to each loaded sample.
module adc_serial_responder
  import adc_link_pkg::*;
#(
  parameter int DATA_W      = adc_link_pkg::DEF_DATA_W,
  parameter int LEAD_ZEROS  = adc_link_pkg::DEF_LEAD_ZEROS,
  parameter int SYNC_STAGES = 2
) (
  input  logic              Clock_Nexys,
  input  logic              Reset_n,
  input  logic              CS,
  input  logic              Clock_Muestreo,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              data_ADC,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_abort
);

  localparam int            FB      = LEAD_ZEROS + DATA_W;
  localparam int            CW      = $clog2(FB);
  localparam logic [CW-1:0] LZ_LAST = CW'(LEAD_ZEROS - 1);
  localparam logic [CW-1:0] FB_LAST = CW'(FB - 1);

  logic cs_fall, cs_rise, sclk_fall, sclk_rise_nc;

  // CS idles high, so its synchroniser resets high to avoid a phantom fall
  edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .gclk(Clock_Nexys), .grst_n(Reset_n), .d(CS), .fall(cs_fall), .rise(cs_rise)
  );

  edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .gclk(Clock_Nexys), .grst_n(Reset_n), .d(Clock_Muestreo),
    .fall(sclk_fall), .rise(sclk_rise_nc)
  );

  adc_state_e        state_q, state_d;
  logic [CW-1:0]     bit_cnt_q;
  logic [DATA_W-1:0] shreg_q, frame_q, last_q, hold_q, load_src, tx_word;
  logic              hold_full_q, xfer;
  logic              data_q, busy_q, done_q, abort_q;
  logic              data_d, busy_d, done_d, abort_d;
  logic              load, shift, cnt_clr, cnt_inc;

  assign xfer     = sample_valid & ~hold_full_q;
  assign load_src = hold_full_q ? hold_q : last_q;

`ifdef ADC_DITHER_EN
  logic [15:0]       lfsr_q;
  logic [DATA_W+1:0] dith_t, dith_m1;

  // Galois LFSR steps once per frame load
  always_ff @(posedge Clock_Nexys or negedge Reset_n) begin
    if (!Reset_n)  lfsr_q <= LFSR_SEED;
    else if (load) lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_POLY : 16'h0000);
  end

  // dith_t = sample + b0 - b1 + 1 keeps the sum non-negative; clamp both ends
  always_comb begin
    dith_t  = {2'b00, load_src} + {{(DATA_W+1){1'b0}}, lfsr_q[0]}
                                + {{(DATA_W+1){1'b0}}, ~lfsr_q[1]};
    dith_m1 = dith_t - (DATA_W+2)'(1);
    if (dith_t == '0)                     tx_word = '0;
    else if (dith_m1[DATA_W+1:DATA_W] != 2'b00) tx_word = '1;
    else                                  tx_word = dith_m1[DATA_W-1:0];
  end
`else
  assign tx_word = load_src;
`endif

  // State register and registered serial outputs
  always_ff @(posedge Clock_Nexys or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      data_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  // Next state and output decode; a CS rise always beats a simultaneous SCLK fall
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      IDLE: begin
        data_d = 1'b0;
        if (cs_fall) begin
          state_d = ZEROS;
          busy_d  = 1'b1;
          load    = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      ZEROS, DATA: begin
        if (cs_rise) begin
          state_d = IDLE;
          data_d  = 1'b0;
          busy_d  = 1'b0;
          abort_d = 1'b1;
        end else if (sclk_fall) begin
          cnt_inc = 1'b1;
          if (state_q == ZEROS) begin
            if (bit_cnt_q == LZ_LAST) begin
              state_d = DATA;
              data_d  = shreg_q[DATA_W-1];
              shift   = 1'b1;
            end
          end else if (bit_cnt_q == FB_LAST) begin
            state_d = DONE;
            data_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            data_d = shreg_q[DATA_W-1];
            shift  = 1'b1;
          end
        end
      end
      DONE: begin
        data_d = 1'b0;
        if (cs_rise) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame bit counter, saturating at the last frame bit
  always_ff @(posedge Clock_Nexys or negedge Reset_n) begin
    if (!Reset_n)                           bit_cnt_q <= '0;
    else if (cnt_clr)                       bit_cnt_q <= '0;
    else if (cnt_inc && bit_cnt_q != FB_LAST) bit_cnt_q <= bit_cnt_q + CW'(1);
  end

  // Shift register, undithered frame copy, and last completed sample
  always_ff @(posedge Clock_Nexys or negedge Reset_n) begin
    if (!Reset_n) begin
      shreg_q <= '0;
      frame_q <= '0;
      last_q  <= '0;
    end else begin
      if (load) begin
        shreg_q <= tx_word;
        frame_q <= load_src;
      end else if (shift) begin
        shreg_q <= {shreg_q[DATA_W-2:0], 1'b0};
      end
      if (done_d) last_q <= frame_q;
    end
  end

  // One-deep holding register; a frame load frees it unless a new transfer lands
  always_ff @(posedge Clock_Nexys or negedge Reset_n) begin
    if (!Reset_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else if (xfer) begin
      hold_q      <= sample_data;
      hold_full_q <= 1'b1;
    end else if (load) begin
      hold_full_q <= 1'b0;
    end
  end

  assign sample_ready = ~hold_full_q;
  assign data_ADC     = data_q;
  assign busy         = busy_q;
  assign frame_done   = done_q;
  assign frame_abort  = abort_q;

endmodule

// File: tb/tb_adc_serial_responder.sv
// tb_adc_serial_responder: bench master for the serial ADC emulator. Frames are
// checked against a queue-based model of the holding register / repeat rules.
module tb_adc_serial_responder;

  logic        Clock_Nexys = 1'b0;
  logic        Reset_n;
  logic        CS;
  logic        Clock_Muestreo;
  logic [11:0] sample_data;
  logic        sample_valid;
  logic        sample_ready, data_ADC, busy, frame_done, frame_abort;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int n_abort = 0;

  logic [11:0] drv_q[$];   // samples the handshake driver still has to deliver
  logic [11:0] m_pend[$];  // model: offered, not yet in the holding register
  logic [11:0] m_hold;
  logic        m_hold_v;
  logic [11:0] m_last;

  adc_serial_responder dut (
    .Clock_Nexys(Clock_Nexys), .Reset_n(Reset_n), .CS(CS),
    .Clock_Muestreo(Clock_Muestreo), .sample_data(sample_data),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .data_ADC(data_ADC), .busy(busy), .frame_done(frame_done),
    .frame_abort(frame_abort)
  );

  always #5 Clock_Nexys = ~Clock_Nexys;

  // Pulse counters
  always @(posedge Clock_Nexys) begin
    if (frame_done)  n_done++;
    if (frame_abort) n_abort++;
  end

  // Handshake: retire the presented sample when it is accepted
  always @(posedge Clock_Nexys)
    if (Reset_n && sample_valid && sample_ready && drv_q.size() > 0) void'(drv_q.pop_front());

  // Present the head of the driver queue away from the active edge
  initial begin
    sample_valid = 1'b0;
    sample_data  = '0;
    forever begin
      @(negedge Clock_Nexys);
      sample_valid = (drv_q.size() > 0);
      if (drv_q.size() > 0) sample_data = drv_q[0];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge Clock_Nexys);
  endtask

  task automatic offer(input logic [11:0] v);
    drv_q.push_back(v);
    m_pend.push_back(v);
    if (!m_hold_v) begin
      m_hold   = m_pend.pop_front();
      m_hold_v = 1'b1;
    end
  endtask

  // Master frame: nfalls SCLK periods (rise then fall, 4+4 cycles); if simul,
  // CS rises together with the final fall. Checks against the model.
  task automatic do_frame(input int nfalls, input bit simul, input string tag);
    logic [15:0] bits, w;
    logic [11:0] tx;
    int          d0, a0;
    bit          complete;
    complete = (nfalls == 16) && !simul;
    if (m_hold_v) begin
      tx       = m_hold;
      m_hold_v = 1'b0;
    end else begin
      tx = m_last;
    end
    if (m_pend.size() > 0) begin
      m_hold   = m_pend.pop_front();
      m_hold_v = 1'b1;
    end
    d0 = n_done; a0 = n_abort; bits = '0;
    CS = 1'b0;
    cyc(4);
    chk({tag, " busy_in_frame"}, busy, 1);
    for (int p = 0; p < nfalls; p++) begin
      Clock_Muestreo = 1'b1;
      bits = {bits[14:0], data_ADC};
      cyc(4);
      if (simul && p == nfalls - 1) CS = 1'b1;
      Clock_Muestreo = 1'b0;
      cyc(4);
    end
    CS = 1'b1;
    cyc(6);
    w = {4'h0, tx};
    w = w >> (16 - nfalls);
    chk({tag, " bits"}, bits, w);
    chk({tag, " done_pulses"}, n_done - d0, complete ? 1 : 0);
    chk({tag, " abort_pulses"}, n_abort - a0, complete ? 0 : 1);
    chk({tag, " busy_after"}, busy, 0);
    chk({tag, " data_idle"}, data_ADC, 0);
    chk({tag, " ready"}, sample_ready, !m_hold_v);
    if (complete) m_last = tx;
  endtask

  initial begin
    Reset_n = 1'b0; CS = 1'b1; Clock_Muestreo = 1'b0;
    m_hold = '0; m_hold_v = 1'b0; m_last = '0;
    cyc(3);
    Reset_n = 1'b1;
    cyc(4);
    chk("rst data", data_ADC, 0);
    chk("rst busy", busy, 0);
    chk("rst ready", sample_ready, 1);
    chk("rst done", frame_done, 0);
    chk("rst abort", frame_abort, 0);

    // basic frame
    offer(12'hA5C); cyc(4);
    chk("a5c ready_full", sample_ready, 0);
    do_frame(16, 0, "a5c");

    // repeat with no new sample
    offer(12'h3FF); cyc(4);
    do_frame(16, 0, "3ff_first");
    chk("3ff ready_stays", sample_ready, 1);
    do_frame(16, 0, "3ff_repeat");

    // back-to-back offers, second one stalls
    offer(12'h001); offer(12'h800); cyc(4);
    chk("b2b stall", sample_ready, 0);
    do_frame(16, 0, "b2b_001");
    do_frame(16, 0, "b2b_800");

    // abort after 7 falls, then repeat of last completed sample
    offer(12'h5A5); cyc(4);
    do_frame(7, 0, "abort7");
    do_frame(16, 0, "after_abort");

    // CS rise coincident with the final SCLK fall
    offer(12'h0F0); cyc(4);
    do_frame(16, 1, "simul16");

    // reset during DATA
    offer(12'hBEE); cyc(4);
    CS = 1'b0; cyc(4);
    for (int p = 0; p < 8; p++) begin
      Clock_Muestreo = 1'b1; cyc(4);
      Clock_Muestreo = 1'b0; cyc(4);
    end
    Reset_n = 1'b0;
    cyc(1);
    chk("midrst data", data_ADC, 0);
    chk("midrst busy", busy, 0);
    chk("midrst ready", sample_ready, 1);
    CS = 1'b1; drv_q.delete(); m_pend.delete();
    m_hold_v = 1'b0; m_last = '0;
    cyc(2);
    Reset_n = 1'b1;
    cyc(4);
    do_frame(16, 0, "post_rst");

    // randomized traffic
    for (int i = 0; i < 25; i++) begin
      int no, r;
      no = $urandom_range(0, 2);
      for (int k = 0; k < no; k++) offer(12'($urandom_range(0, 4095)));
      cyc(4);
      r = $urandom_range(0, 9);
      if (r < 7)      do_frame(16, 0, "rnd_full");
      else if (r < 9) do_frame($urandom_range(1, 15), 0, "rnd_abort");
      else            do_frame($urandom_range(1, 16), 1, "rnd_simul");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
